// File: rtl/rvb_pkg.sv
// rvb_pkg
// Shared encodings and tag format for the bext/bdep dispatch block.
//   - opcode / funct3 / funct7 constants for bext, bdep and grev
//   - tag_t: per-instruction writeback tag {rd, illegal} carried by the tag FIFO
//   - insn_legal(): legality decode from the major instruction fields
package rvb_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [2:0] F3_BEXTDEP = 3'b110;
    localparam logic [2:0] F3_GREV    = 3'b101;
    localparam logic [6:0] F7_BEXT    = 7'b0000100;
    localparam logic [6:0] F7_BDEP    = 7'b0100100;
    localparam logic [6:0] F7_GREV    = 7'b0110100;

    typedef struct packed {
        logic [4:0] rd;
        logic       illegal;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // w_ok enables the OP-32 (W-form) opcode; grev_en admits the grev encoding.
    function automatic logic insn_legal(
        input logic [6:0] opc,
        input logic [2:0] f3,
        input logic [6:0] f7,
        input logic       w_ok,
        input logic       grev_en
    );
        logic op_ok;
        logic bx;
        logic gv;
        op_ok = (opc == OPC_OP) || (w_ok && (opc == OPC_OP32));
        bx    = (f3 == F3_BEXTDEP) && ((f7 == F7_BEXT) || (f7 == F7_BDEP));
        gv    = grev_en && (f3 == F3_GREV) && (f7 == F7_GREV);
        return op_ok && (bx || gv);
    endfunction

endpackage

// File: rtl/rvb_tagfifo.sv
// rvb_tagfifo
// Small synchronous FIFO holding writeback tags in acceptance order.
// Ports:
//   clock, resetn   clock, asynchronous active-low reset (pointers/count only)
//   push, din       write strobe and tag; caller never pushes when full
//   pop             read strobe; caller never pops when empty
//   dout            head entry (combinational read of the oldest tag)
//   count           occupancy 0..DEPTH
module rvb_tagfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/rvb_bextdep_dispatch.sv
// rvb_bextdep_dispatch
// Issue-side dispatcher for a bext/bdep (optionally grev) execution unit.
// Legal instructions are forwarded to the core through a one-entry request
// register; every accepted instruction (legal or not) leaves a tag in an
// in-order FIFO so results return strictly in acceptance order, with illegal
// instructions answered locally (out_illegal=1, out_data=0).
// Ports:
//   clock, resetn                    clock, asynchronous active-low reset
//   in_valid/in_ready, in_insn,
//   in_rs1, in_rs2, in_rd            upstream issue handshake and operands
//   core_din_valid/core_din_ready,
//   core_din_rs1/rs2, core_din_insn3/13/14/30   request to the core
//   core_dout_valid/core_dout_ready, core_dout_rd  result from the core
//   out_valid/out_ready, out_rd_idx,
//   out_data, out_illegal            writeback handshake
// Configuration macro: RVB_DISPATCH_GREV_EN (defined: grev/grevw are legal).
module rvb_bextdep_dispatch #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    output logic            core_din_valid,
    input  logic            core_din_ready,
    output logic [XLEN-1:0] core_din_rs1,
    output logic [XLEN-1:0] core_din_rs2,
    output logic            core_din_insn3,
    output logic            core_din_insn13,
    output logic            core_din_insn14,
    output logic            core_din_insn30,
    input  logic            core_dout_valid,
    output logic            core_dout_ready,
    input  logic [XLEN-1:0] core_dout_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd_idx,
    output logic [XLEN-1:0] out_data,
    output logic            out_illegal
);

    import rvb_pkg::*;

    localparam int   CW   = $clog2(DEPTH + 1);
    localparam logic W_OK = (XLEN == 64);
`ifdef RVB_DISPATCH_GREV_EN
    localparam logic GREV_EN = 1'b1;
`else
    localparam logic GREV_EN = 1'b0;
`endif

    logic [6:0]    opc;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic          in_legal;
    logic          accept;
    logic          pop;
    logic          live;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    tag_t          push_tag;
    tag_t          head_tag;
    logic [TAG_W-1:0] head_bits;
    logic          head_legal;

    logic            req_vld_p1;
    logic [XLEN-1:0] req_rs1_p1;
    logic [XLEN-1:0] req_rs2_p1;
    logic [3:0]      req_bits_p1;

    // Register-number fields are not needed for dispatch.
    logic unused_insn_fields;
    assign unused_insn_fields = ^{in_insn[24:15], in_insn[11:7]};

    assign opc      = in_insn[6:0];
    assign f3       = in_insn[14:12];
    assign f7       = in_insn[31:25];
    assign in_legal = insn_legal(opc, f3, f7, W_OK, GREV_EN);

    assign fifo_full  = (fifo_count == CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);

    // live holds in_ready low throughout reset and for the first cycle after it.
    assign in_ready = live && !fifo_full && (!req_vld_p1 || core_din_ready);
    assign accept   = in_valid && in_ready;

    assign push_tag.rd      = in_rd;
    assign push_tag.illegal = !in_legal;

    // ---- stage p0 -> p1: request register toward the core ----
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            live       <= 1'b0;
            req_vld_p1 <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept && in_legal)
                req_vld_p1 <= 1'b1;
            else if (core_din_ready)
                req_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (accept && in_legal) begin
            req_rs1_p1  <= in_rs1;
            req_rs2_p1  <= in_rs2;
            req_bits_p1 <= {in_insn[3], in_insn[13], in_insn[14], in_insn[30]};
        end
    end

    // Data is qualified by valid so the request bus reads zero when idle.
    assign core_din_valid  = req_vld_p1;
    assign core_din_rs1    = req_vld_p1 ? req_rs1_p1 : '0;
    assign core_din_rs2    = req_vld_p1 ? req_rs2_p1 : '0;
    assign core_din_insn3  = req_vld_p1 && req_bits_p1[3];
    assign core_din_insn13 = req_vld_p1 && req_bits_p1[2];
    assign core_din_insn14 = req_vld_p1 && req_bits_p1[1];
    assign core_din_insn30 = req_vld_p1 && req_bits_p1[0];

    rvb_tagfifo #(
        .DEPTH(DEPTH),
        .WIDTH(TAG_W)
    ) u_tagfifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (accept),
        .din    (push_tag),
        .pop    (pop),
        .dout   (head_bits),
        .count  (fifo_count)
    );

    // ---- writeback: head tag selects core result or local illegal answer ----
    assign head_tag   = tag_t'(head_bits);
    assign head_legal = !fifo_empty && !head_tag.illegal;

    assign out_valid       = !fifo_empty && (head_tag.illegal || core_dout_valid);
    assign core_dout_ready = out_ready && head_legal;
    assign pop             = out_valid && out_ready;

    assign out_rd_idx  = fifo_empty ? 5'd0 : head_tag.rd;
    assign out_illegal = !fifo_empty && head_tag.illegal;
    assign out_data    = head_legal ? core_dout_rd : '0;

endmodule

// File: tb/tb_rvb_bextdep_dispatch.sv
module tb_rvb_bextdep_dispatch;

    localparam logic [31:0] I_BEXT  = 32'h08006033;
    localparam logic [31:0] I_BDEP  = 32'h48006033;
    localparam logic [31:0] I_GREV  = 32'h68005033;
    localparam logic [31:0] I_ADDI  = 32'h00000013;
    localparam logic [31:0] I_BEXTW = 32'h0800603B;
    localparam logic [31:0] I_BXF3  = 32'h08007033;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_insn = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic        core_din_valid;
    logic        core_din_ready = 1'b1;
    logic [31:0] core_din_rs1;
    logic [31:0] core_din_rs2;
    logic        core_din_insn3, core_din_insn13, core_din_insn14, core_din_insn30;
    logic        core_dout_valid = 1'b0;
    logic        core_dout_ready;
    logic [31:0] core_dout_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_rd_idx;
    logic [31:0] out_data;
    logic        out_illegal;

    always #5 clock = ~clock;

    rvb_bextdep_dispatch #(.XLEN(32), .DEPTH(4)) dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .core_din_valid(core_din_valid), .core_din_ready(core_din_ready),
        .core_din_rs1(core_din_rs1), .core_din_rs2(core_din_rs2),
        .core_din_insn3(core_din_insn3), .core_din_insn13(core_din_insn13),
        .core_din_insn14(core_din_insn14), .core_din_insn30(core_din_insn30),
        .core_dout_valid(core_dout_valid), .core_dout_ready(core_dout_ready),
        .core_dout_rd(core_dout_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd_idx(out_rd_idx),
        .out_data(out_data), .out_illegal(out_illegal)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic logic [31:0] f_bext(input logic [31:0] a, input logic [31:0] m);
        logic [31:0] r;
        int k;
        r = '0; k = 0;
        for (int i = 0; i < 32; i++)
            if (m[i]) begin r[k] = a[i]; k++; end
        return r;
    endfunction

    function automatic logic [31:0] f_bdep(input logic [31:0] a, input logic [31:0] m);
        logic [31:0] r;
        int k;
        r = '0; k = 0;
        for (int i = 0; i < 32; i++)
            if (m[i]) begin r[i] = a[k]; k++; end
        return r;
    endfunction

    // Generalised reverse: bit i moves to position i XOR shamt.
    function automatic logic [31:0] f_grev(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(b[4:0]);
        r = '0;
        for (int i = 0; i < 32; i++) r[i ^ sh] = a[i];
        return r;
    endfunction

    function automatic void ref_model(input logic [31:0] insn, input logic [31:0] a,
                                      input logic [31:0] b, output logic ill,
                                      output logic [31:0] res);
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc = insn[6:0]; f3 = insn[14:12]; f7 = insn[31:25];
        ill = 1'b1; res = '0;
        if (opc == 7'h33 && f3 == 3'd6 && f7 == 7'h04) begin ill = 1'b0; res = f_bext(a, b); end
        else if (opc == 7'h33 && f3 == 3'd6 && f7 == 7'h24) begin ill = 1'b0; res = f_bdep(a, b); end
`ifdef RVB_DISPATCH_GREV_EN
        else if (opc == 7'h33 && f3 == 3'd5 && f7 == 7'h34) begin ill = 1'b0; res = f_grev(a, b); end
`endif
    endfunction

    // Execution-unit model: chooses the operation from the forwarded insn bits.
    function automatic logic [31:0] core_compute(input logic [3:0] bits, input logic [31:0] a,
                                                 input logic [31:0] b);
        if (bits[2] && bits[1]) return bits[0] ? f_bdep(a, b) : f_bext(a, b);
        if (bits[1] && !bits[2]) return f_grev(a, b);
        return 32'hDEADBEEF;
    endfunction

    typedef struct { logic [4:0] rd; logic ill; logic [31:0] data; } res_t;
    typedef struct { logic [31:0] rs1; logic [31:0] rs2; logic [3:0] bits; } req_t;

    res_t        exp_q[$];
    res_t        out_log[$];
    req_t        req_q[$];
    logic [31:0] core_q[$];
    int          core_req_cnt = 0;
    bit          rand_mode = 1'b0;
    logic        out_ready_fix = 1'b0;

    res_t        mon_e;
    req_t        mon_r;
    logic        mon_ill;
    logic [31:0] mon_d;

    // Environment drivers: out_ready and the core side, just after each rising edge.
    always @(posedge clock) begin
        #2;
        out_ready      = rand_mode ? ($urandom_range(0, 3) != 0) : out_ready_fix;
        core_din_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (core_q.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
            core_dout_valid = 1'b1;
            core_dout_rd    = core_q[0];
        end else begin
            core_dout_valid = 1'b0;
            core_dout_rd    = $urandom;
        end
    end

    // Monitor / scoreboard: handshakes seen at the falling edge complete on the next rise.
    always @(negedge clock) begin
        if (!resetn) begin
            exp_q.delete(); req_q.delete(); core_q.delete();
        end else begin
            if (core_dout_valid && core_dout_ready) void'(core_q.pop_front());
            if (core_din_valid && core_din_ready) begin
                chk("core_req_expected", 64'(req_q.size() != 0), 64'(1));
                if (req_q.size() != 0) begin
                    mon_r = req_q.pop_front();
                    chk("core_rs1", 64'(core_din_rs1), 64'(mon_r.rs1));
                    chk("core_rs2", 64'(core_din_rs2), 64'(mon_r.rs2));
                    chk("core_bits", 64'({core_din_insn3, core_din_insn13, core_din_insn14,
                                          core_din_insn30}), 64'(mon_r.bits));
                end
                core_q.push_back(core_compute({core_din_insn3, core_din_insn13, core_din_insn14,
                                               core_din_insn30}, core_din_rs1, core_din_rs2));
                core_req_cnt++;
            end
            if (out_valid && out_ready) begin
                chk("out_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("sb_rd", 64'(out_rd_idx), 64'(mon_e.rd));
                    chk("sb_illegal", 64'(out_illegal), 64'(mon_e.ill));
                    chk("sb_data", 64'(out_data), 64'(mon_e.data));
                end
                out_log.push_back('{rd: out_rd_idx, ill: out_illegal, data: out_data});
            end
            if (in_valid && in_ready) begin
                ref_model(in_insn, in_rs1, in_rs2, mon_ill, mon_d);
                exp_q.push_back('{rd: in_rd, ill: mon_ill, data: mon_d});
                if (!mon_ill)
                    req_q.push_back('{rs1: in_rs1, rs2: in_rs2,
                                      bits: {in_insn[3], in_insn[13], in_insn[14], in_insn[30]}});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int n;
        n = 0;
        in_valid = 1'b1; in_insn = insn; in_rs1 = a; in_rs2 = b; in_rd = rd;
        @(negedge clock);
        while (!in_ready && n < 200) begin @(negedge clock); n++; end
        chk("issue_accept", 64'(in_ready), 64'(1));
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_log(input int target);
        int n;
        n = 0;
        while (out_log.size() < target && n < 200) begin @(negedge clock); n++; end
        chk("log_wait", 64'(out_log.size() >= target), 64'(1));
        @(posedge clock); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge clock); n++; end
        chk("drain", 64'(exp_q.size()), 64'(0));
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic [31:0] insn; logic [31:0] rs1; logic [31:0] rs2; logic [4:0] rd;
        logic [31:0] exp_data; logic exp_ill;
    } vec_t;
    vec_t vecs[9];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [31:0] insn;
        vecs[0] = '{I_BEXT, 32'h12345678, 32'h0000FF00, 5'd5, 32'h00000056, 1'b0};
        vecs[1] = '{I_BDEP, 32'h000000AB, 32'hFF000000, 5'd7, 32'hAB000000, 1'b0};
        vecs[2] = '{I_ADDI, 32'h00001111, 32'h00002222, 5'd3, 32'h00000000, 1'b1};
`ifdef RVB_DISPATCH_GREV_EN
        vecs[3] = '{I_GREV, 32'h00000001, 32'h0000001F, 5'd9, 32'h80000000, 1'b0};
`else
        vecs[3] = '{I_GREV, 32'h00000001, 32'h0000001F, 5'd9, 32'h00000000, 1'b1};
`endif
        vecs[4] = '{I_BEXT | 32'h00A50F80, 32'hFFFFFFFF, 32'hF0F0F0F0, 5'd0, 32'h0000FFFF, 1'b0};
        vecs[5] = '{I_BDEP, 32'h00000005, 32'h0000F000, 5'd31, 32'h00005000, 1'b0};
        vecs[6] = '{I_BEXTW, 32'h12345678, 32'h0000FF00, 5'd4, 32'h00000000, 1'b1};
        vecs[7] = '{I_BXF3, 32'h12345678, 32'h0000FF00, 5'd6, 32'h00000000, 1'b1};
        vecs[8] = '{I_BEXT, 32'h80000001, 32'h80000001, 5'd2, 32'h00000003, 1'b0};

        // Reset state
        #1 resetn = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_core_din_valid", 64'(core_din_valid), 64'(0));
        chk("rst_core_dout_ready", 64'(core_dout_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_rd_idx", 64'(out_rd_idx), 64'(0));
        chk("rst_out_illegal", 64'(out_illegal), 64'(0));
        chk("rst_core_din_rs1", 64'(core_din_rs1), 64'(0));
        @(posedge clock); #1;
        resetn = 1'b1;
        out_ready_fix = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 9; i++) begin
            n0 = out_log.size();
            issue(vecs[i].insn, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
            wait_log(n0 + 1);
            if (out_log.size() > n0) begin
                chk($sformatf("vec%0d_data", i), 64'(out_log[n0].data), 64'(vecs[i].exp_data));
                chk($sformatf("vec%0d_rd", i), 64'(out_log[n0].rd), 64'(vecs[i].rd));
                chk($sformatf("vec%0d_illegal", i), 64'(out_log[n0].ill), 64'(vecs[i].exp_ill));
            end
        end

        // Illegal op between two bext ops never reaches the core
        n0 = out_log.size();
        begin
            int c0;
            c0 = core_req_cnt;
            issue(I_BEXT, 32'h12345678, 32'h0000FF00, 5'd1);
            issue(I_ADDI, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
            issue(I_BEXT, 32'h12345678, 32'h00FF0000, 5'd2);
            wait_idle();
            chk("mix_core_reqs", 64'(core_req_cnt - c0), 64'(2));
        end
        chk("mix_count", 64'(out_log.size()), 64'(n0 + 3));
        if (out_log.size() >= n0 + 3) begin
            chk("mix0_rd", 64'(out_log[n0].rd), 64'(1));
            chk("mix0_data", 64'(out_log[n0].data), 64'(32'h56));
            chk("mix1_rd", 64'(out_log[n0+1].rd), 64'(3));
            chk("mix1_illegal", 64'(out_log[n0+1].ill), 64'(1));
            chk("mix1_data", 64'(out_log[n0+1].data), 64'(0));
            chk("mix2_rd", 64'(out_log[n0+2].rd), 64'(2));
            chk("mix2_data", 64'(out_log[n0+2].data), 64'(32'h34));
        end

        // Backpressure: FIFO fills after four accepts
        out_ready_fix = 1'b0;
        @(posedge clock); #1;
        n0 = out_log.size();
        for (int k = 0; k < 4; k++)
            issue(I_BDEP, 32'(k + 1), 32'h000000F0, 5'(11 + k));
        in_valid = 1'b1; in_insn = I_BDEP; in_rs1 = 32'd5; in_rs2 = 32'h000000F0; in_rd = 5'd15;
        repeat (4) begin
            @(negedge clock);
            chk("full_in_ready", 64'(in_ready), 64'(0));
        end
        chk("full_out_valid", 64'(out_valid), 64'(1));
        @(posedge clock); #1;
        out_ready_fix = 1'b1;
        issue(I_BDEP, 32'd5, 32'h000000F0, 5'd15);
        wait_idle();
        chk("full_count", 64'(out_log.size()), 64'(n0 + 5));
        if (out_log.size() >= n0 + 5)
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("full%0d_rd", k), 64'(out_log[n0+k].rd), 64'(11 + k));
                chk($sformatf("full%0d_data", k), 64'(out_log[n0+k].data), 64'((k + 1) << 4));
            end

        // Reset with three ops in flight
        out_ready_fix = 1'b0;
        @(posedge clock); #1;
        issue(I_BEXT, 32'hAAAA5555, 32'h0000FFFF, 5'd20);
        issue(I_BEXT, 32'hAAAA5555, 32'hFFFF0000, 5'd21);
        issue(I_BDEP, 32'h0000000F, 32'h000F0000, 5'd22);
        #2 resetn = 1'b0;
        @(negedge clock);
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        chk("mid_rst_core_din_valid", 64'(core_din_valid), 64'(0));
        chk("mid_rst_out_rd_idx", 64'(out_rd_idx), 64'(0));
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        chk("post_rst_out_valid", 64'(out_valid), 64'(0));
        chk("post_rst_core_din_valid", 64'(core_din_valid), 64'(0));
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clock); #1;
        out_ready_fix = 1'b1;
        n0 = out_log.size();
        issue(I_BDEP, 32'h000000AB, 32'hFF000000, 5'd7);
        wait_idle();
        chk("post_rst_count", 64'(out_log.size()), 64'(n0 + 1));
        if (out_log.size() > n0) begin
            chk("post_rst_rd", 64'(out_log[n0].rd), 64'(7));
            chk("post_rst_data", 64'(out_log[n0].data), 64'(32'hAB000000));
        end

        // Randomised traffic against the scoreboard
        rand_mode = 1'b1;
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 5))
                0: insn = I_BEXT;
                1: insn = I_BDEP;
                2: insn = I_GREV;
                3: insn = I_ADDI;
                4: insn = $urandom;
                default: insn = I_BEXTW;
            endcase
            if (insn != I_ADDI) insn = insn | ($urandom & 32'h01FF8F80);
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            issue(insn, $urandom, $urandom, 5'($urandom));
        end
        rand_mode = 1'b0;
        out_ready_fix = 1'b1;
        wait_idle();
        chk("rand_req_left", 64'(req_q.size()), 64'(0));
        chk("rand_core_left", 64'(core_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rvb_bextdep_dispatch.md
RVB_BEXTDEP_DISPATCH -- requirements
Module: rvb_bextdep_dispatch

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 4, tag FIFO entries (power of two, 2..16).
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  reset; asynchronous, active-low.
REQ-005 in_valid/in_ready  input/output  1/1  upstream issue handshake.
REQ-006 in_insn  input  32  full instruction word.
REQ-007 in_rs1, in_rs2  input  XLEN  operand values.
REQ-008 in_rd  input  5  destination register index.
REQ-009 core_din_valid/core_din_ready  output/input  1/1  request handshake to the bext/bdep unit.
REQ-010 core_din_rs1, core_din_rs2  output  XLEN; core_din_insn3/13/14/30  output  1 each  decoded insn bits.
REQ-011 core_dout_valid/core_dout_ready  input/output  1/1; core_dout_rd  input  XLEN  result.
REQ-012 out_valid/out_ready  output/input  1/1  writeback handshake.
REQ-013 out_rd_idx  output  5; out_data  output  XLEN; out_illegal  output  1.

Function
REQ-014 Legal: opcode 0110011 with (funct7 0000100, funct3 110)=bext or (funct7 0100100, funct3 110)=bdep; for XLEN=64 also opcode 0111011 with the same funct7/funct3 (W forms).
REQ-015 All other encodings illegal; illegal insns never reach the core.
REQ-016 in_ready = tag FIFO not full AND (request register empty OR core_din_ready), independent of legality.
REQ-017 Accept (in_valid&&in_ready) in cycle N: push {in_rd, illegal} to tag FIFO; if legal, load request register, core_din_valid high from cycle N+1.
REQ-018 core_din_* held stable while core_din_valid && !core_din_ready; register clears on handshake unless reloaded same cycle.
REQ-019 out_valid = FIFO non-empty AND (head.illegal OR core_dout_valid).
REQ-020 core_dout_ready = out_ready AND FIFO non-empty AND !head.illegal.
REQ-021 Legal head: out_data=core_dout_rd, out_illegal=0; illegal head: out_data=0, out_illegal=1; out_rd_idx=head.rd.
REQ-022 FIFO pops on out_valid&&out_ready; push and pop in the same cycle leave the count unchanged; count range 0..DEPTH, pointers wrap modulo DEPTH.
REQ-023 Results are returned strictly in acceptance order, legal and illegal interleaved.
REQ-024 rd index 0 is carried like any other index.

Reset
REQ-025 While resetn=0: in_ready=0, core_din_valid=0, core_dout_ready=0, out_valid=0, FIFO count=0, request register empty; data outputs 0.
REQ-026 Reset mid-operation discards all in-flight tags and requests; the core is reset by the same resetn.

Configuration
REQ-027 Macro RVB_DISPATCH_GREV_EN defined: funct7 0110100 funct3 101 (grev, plus grevw when XLEN=64) is legal and forwarded with the same bit mapping.
REQ-028 Macro RVB_DISPATCH_GREV_EN undefined: the grev encodings are illegal.

Structure
REQ-029 Shared package rvb_pkg holds opcode/funct3/funct7 constants and the tag struct {rd[4:0], illegal}.
REQ-030 Tag FIFO is one sub-module rvb_tagfifo (DEPTH, WIDTH parameters, count output).

Verification
REQ-031 bext rs1=0x12345678 rs2=0x0000FF00 rd=5 -> out_data=0x00000056, out_rd_idx=5, out_illegal=0.
REQ-032 bdep rs1=0x000000AB rs2=0xFF000000 rd=7 -> out_data=0xAB000000, out_rd_idx=7.
REQ-033 insn 0x00000013 (addi) rd=3 between two bext ops -> core_din_valid never asserted for it; outputs in order, middle out_illegal=1, out_data=0.
REQ-034 out_ready=0, DEPTH=4, issue 5 legal ops -> in_ready low after 4th accept; raise out_ready -> all 5 complete in order.
REQ-035 grev rs1=0x00000001 rs2=0x0000001F -> out_data=0x80000000 with RVB_DISPATCH_GREV_EN, out_illegal=1 without.
REQ-036 resetn low with 3 ops in flight -> out_valid=0 next cycle; FIFO empty after release.
